// File: rtl/weak_bus_ctrl_if.sv
// Bus bundle between the RV32I core's shared port and weak_bus_ctrl.
// bus_err exists only when WEAK_BUS_ERR_EN is defined.
interface weak_bus_ctrl_if;
  logic        bus_req;
  logic [31:0] bus_addr;
  logic        bus_wr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ack;
`ifdef WEAK_BUS_ERR_EN
  logic        bus_err;

  modport master (
    output bus_req, bus_addr, bus_wr, bus_wdata,
    input  bus_rdata, bus_ack, bus_err
  );
  modport slave (
    input  bus_req, bus_addr, bus_wr, bus_wdata,
    output bus_rdata, bus_ack, bus_err
  );
`else
  modport master (
    output bus_req, bus_addr, bus_wr, bus_wdata,
    input  bus_rdata, bus_ack
  );
  modport slave (
    input  bus_req, bus_addr, bus_wr, bus_wdata,
    output bus_rdata, bus_ack
  );
`endif
endinterface

// File: rtl/weak_bus_ctrl.sv
// Bus target for the RV32I core: word RAM at 0, 16-byte MMIO page (TX byte, status,
// cycle counter), acked after WAIT_CYCLES wait states. Optional macro: WEAK_BUS_ERR_EN.
module weak_bus_ctrl #(
  parameter int unsigned RAM_WORDS   = 1024,
  parameter int unsigned WAIT_CYCLES = 1,
  parameter logic [31:0] MMIO_BASE   = 32'h8000_0000
) (
  input  logic             clk,
  input  logic             rst,
  weak_bus_ctrl_if.slave   bus,
  output logic [7:0]       tx_data,
  output logic             tx_valid,
  input  logic             tx_ready
);

  localparam int unsigned AW        = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
  localparam logic [29:0] RAM_LIMIT = 30'(RAM_WORDS);
  localparam logic [3:0]  WAIT_LD   = 4'(WAIT_CYCLES);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_ACK  = 2'd2;
  localparam logic [1:0] S_TXW  = 2'd3;

  localparam logic [1:0] OFF_TX   = 2'd0;
  localparam logic [1:0] OFF_STAT = 2'd1;
  localparam logic [1:0] OFF_CNT  = 2'd2;
  localparam logic [1:0] OFF_ERR  = 2'd3;

  function automatic logic in_ram(input logic [29:0] word);
    return word < RAM_LIMIT;
  endfunction

  function automatic logic in_mmio(input logic [27:0] page);
    return page == MMIO_BASE[31:4];
  endfunction

  logic [1:0]  state;
  logic [3:0]  wait_cnt;
  logic [29:0] addr_q;
  logic        wr_q;
  logic [31:0] wdata_q;
  logic        tx_drop_q;
  logic [31:0] cyc_cnt;
  logic [31:0] mem [RAM_WORDS];
  logic [31:0] ram_rd;
  logic [31:0] rd_mux;

  logic [29:0] req_word;
  logic        req_is_tx;
  logic        acking;
  logic        ram_we;
  logic        mmio_we;
  logic [AW-1:0] rd_idx;

  assign req_word  = bus.bus_addr[31:2];
  assign req_is_tx = bus.bus_wr && in_mmio(req_word[29:2]) && (req_word[1:0] == OFF_TX);
  assign acking    = (state == S_ACK);
  assign ram_we    = acking && wr_q && in_ram(addr_q);
  assign mmio_we   = acking && wr_q && in_mmio(addr_q[29:2]);
  // In IDLE the read port looks at the live address so a zero-wait access has data in ACK.
  assign rd_idx    = (state == S_IDLE) ? req_word[AW-1:0] : addr_q[AW-1:0];

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      wait_cnt  <= 4'd0;
      addr_q    <= '0;
      wr_q      <= 1'b0;
      wdata_q   <= '0;
      tx_drop_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (bus.bus_req) begin
          addr_q    <= req_word;
          wr_q      <= bus.bus_wr;
          wdata_q   <= bus.bus_wdata;
          wait_cnt  <= WAIT_LD;
          tx_drop_q <= 1'b0;
          if (req_is_tx)              state <= S_TXW;
          else if (WAIT_LD == 4'd0)   state <= S_ACK;
          else                        state <= S_WAIT;
        end
        S_WAIT: begin
          if (!bus.bus_req) begin
            state <= S_IDLE;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
            if (wait_cnt <= 4'd1) state <= S_ACK;
          end
        end
        S_TXW: begin
          // A request withdrawn mid-handshake still delivers the byte, just without an ack.
          if (!bus.bus_req) tx_drop_q <= 1'b1;
          if (tx_ready) state <= (bus.bus_req && !tx_drop_q) ? S_ACK : S_IDLE;
        end
        S_ACK: state <= S_IDLE;
      endcase
    end
  end

  // NOTE: RAM contents carry no reset; only the write enable is qualified by rst.
  always_ff @(posedge clk) begin
    if (!rst && ram_we) mem[addr_q[AW-1:0]] <= wdata_q;
    ram_rd <= mem[rd_idx];
  end

  always_ff @(posedge clk) begin
    if (rst)                                   cyc_cnt <= '0;
    else if (mmio_we && addr_q[1:0] == OFF_CNT) cyc_cnt <= wdata_q;
    else                                       cyc_cnt <= cyc_cnt + 32'd1;
  end

`ifdef WEAK_BUS_ERR_EN
  logic        mis_q;
  logic        acc_err;
  logic [31:0] err_reg;

  assign acc_err = mis_q || !(in_ram(addr_q) || in_mmio(addr_q[29:2]));

  always_ff @(posedge clk) begin
    if (rst)                            mis_q <= 1'b0;
    else if (state == S_IDLE && bus.bus_req) mis_q <= |bus.bus_addr[1:0];
  end

  // A new error capture takes priority over a clear landing on the same edge.
  always_ff @(posedge clk) begin
    if (rst)                                     err_reg <= '0;
    else if (acking && acc_err)                  err_reg <= {addr_q, 2'b01};
    else if (mmio_we && addr_q[1:0] == OFF_ERR)  err_reg <= '0;
  end

  assign bus.bus_err = acking && acc_err;
`else
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^bus.bus_addr[1:0];
`endif

  // NOTE: rd_mux gets a default first so no path through the block infers a latch.
  always_comb begin
    rd_mux = '0;
    if (!wr_q) begin
      if (in_ram(addr_q)) begin
        rd_mux = ram_rd;
      end else if (in_mmio(addr_q[29:2])) begin
        case (addr_q[1:0])
          OFF_STAT: rd_mux = {31'b0, tx_ready};
          OFF_CNT:  rd_mux = cyc_cnt;
`ifdef WEAK_BUS_ERR_EN
          OFF_ERR:  rd_mux = err_reg;
`endif
          default:  rd_mux = '0;
        endcase
      end
    end
  end

  assign bus.bus_ack   = acking;
  assign bus.bus_rdata = acking ? rd_mux : '0;
  assign tx_valid      = (state == S_TXW);
  assign tx_data       = tx_valid ? wdata_q[7:0] : 8'h00;

endmodule

// File: tb/tb_weak_bus_ctrl.sv
// Directed bench for weak_bus_ctrl: one instance with WAIT_CYCLES=1, one with WAIT_CYCLES=0.
module tb_weak_bus_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       tx_ready1, tx_ready0;
  logic [7:0] tx_data1, tx_data0;
  logic       tx_valid1, tx_valid0;
  int         total = 0;
  int         bad   = 0;
`ifdef WEAK_BUS_ERR_EN
  logic       last_err;
`endif

  always #5 clk = ~clk;

  weak_bus_ctrl_if bif1 ();
  weak_bus_ctrl_if bif0 ();

  weak_bus_ctrl #(.RAM_WORDS(1024), .WAIT_CYCLES(1), .MMIO_BASE(32'h8000_0000)) dut1 (
    .clk(clk), .rst(rst), .bus(bif1),
    .tx_data(tx_data1), .tx_valid(tx_valid1), .tx_ready(tx_ready1)
  );

  weak_bus_ctrl #(.RAM_WORDS(1024), .WAIT_CYCLES(0), .MMIO_BASE(32'h8000_0000)) dut0 (
    .clk(clk), .rst(rst), .bus(bif0),
    .tx_data(tx_data0), .tx_valid(tx_valid0), .tx_ready(tx_ready0)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit d0, input logic req, input logic [31:0] a,
                       input logic w, input logic [31:0] wd);
    if (d0) begin
      bif0.bus_req = req; bif0.bus_addr = a; bif0.bus_wr = w; bif0.bus_wdata = wd;
    end else begin
      bif1.bus_req = req; bif1.bus_addr = a; bif1.bus_wr = w; bif1.bus_wdata = wd;
    end
  endtask

  function automatic logic ack_of(input bit d0);
    return d0 ? bif0.bus_ack : bif1.bus_ack;
  endfunction

  function automatic logic [31:0] rdata_of(input bit d0);
    return d0 ? bif0.bus_rdata : bif1.bus_rdata;
  endfunction

  // Full transfer: raise req, wait (bounded) for ack, drop req, then check the idle cycle.
  task automatic access(input string tag, input bit d0, input logic [31:0] a, input logic w,
                        input logic [31:0] wd, input logic [31:0] exp_rd, input int exp_lat,
                        input bit chk_rd);
    int          lat;
    bit          got;
    logic [31:0] rd;
    drive(d0, 1'b1, a, w, wd);
    lat = 0;
    got = 0;
    while (!got && lat < 50) begin
      tick;
      lat++;
      if (ack_of(d0) === 1'b1) got = 1;
    end
    rd = rdata_of(d0);
`ifdef WEAK_BUS_ERR_EN
    last_err = d0 ? bif0.bus_err : bif1.bus_err;
`endif
    drive(d0, 1'b0, a, w, wd);
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    if (chk_rd) check({tag, "_rd"}, rd, exp_rd);
    tick;
    check({tag, "_ack_low"}, {31'b0, ack_of(d0)}, 32'd0);
    check({tag, "_rd_idle"}, rdata_of(d0), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    tx_ready1 = 1'b0;
    tx_ready0 = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    repeat (3) tick;

    check("rst_ack",      {31'b0, bif1.bus_ack}, 32'd0);
    check("rst_rdata",    bif1.bus_rdata, 32'd0);
    check("rst_tx_valid", {31'b0, tx_valid1}, 32'd0);
    check("rst_tx_data",  {24'b0, tx_data1}, 32'd0);
    rst = 1'b0;
    tick;

    // Zero-wait instance: ack one cycle after req.
    access("w0_rd0", 1'b1, 32'h0, 1'b0, 32'h0, 32'h0, 1, 1'b0);
    access("w0_wr4", 1'b1, 32'h4, 1'b1, 32'h0000_0055, 32'h0, 1, 1'b1);
    access("w0_rd4", 1'b1, 32'h4, 1'b0, 32'h0, 32'h0000_0055, 1, 1'b1);

    // One-wait instance: RAM write/read.
    access("wr10", 1'b0, 32'h10, 1'b1, 32'hDEAD_BEEF, 32'h0, 2, 1'b1);
    access("rd10", 1'b0, 32'h10, 1'b0, 32'h0, 32'hDEAD_BEEF, 2, 1'b1);
    access("rd13", 1'b0, 32'h13, 1'b0, 32'h0, 32'hDEAD_BEEF, 2, 1'b1);
`ifdef WEAK_BUS_ERR_EN
    check("rd13_err", {31'b0, last_err}, 32'd1);
`endif

    // TX byte with tx_ready held low for 5 cycles.
    tx_ready1 = 1'b0;
    drive(1'b0, 1'b1, 32'h8000_0000, 1'b1, 32'h0000_0041);
    tick;
    for (int i = 0; i < 5; i++) begin
      check("tx_valid_hold", {31'b0, tx_valid1}, 32'd1);
      check("tx_data_hold",  {24'b0, tx_data1}, 32'h41);
      check("tx_no_ack",     {31'b0, bif1.bus_ack}, 32'd0);
      tick;
    end
    tx_ready1 = 1'b1;
    tick;
    check("tx_ack",       {31'b0, bif1.bus_ack}, 32'd1);
    check("tx_valid_off", {31'b0, tx_valid1}, 32'd0);
    check("tx_ack_rdata", bif1.bus_rdata, 32'd0);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    tx_ready1 = 1'b0;
    tick;
    check("tx_ack_once",  {31'b0, bif1.bus_ack}, 32'd0);

    // Status register reflects tx_ready.
    tx_ready1 = 1'b1;
    access("stat1", 1'b0, 32'h8000_0004, 1'b0, 32'h0, 32'h1, 2, 1'b1);
    tx_ready1 = 1'b0;
    access("stat0", 1'b0, 32'h8000_0004, 1'b0, 32'h0, 32'h0, 2, 1'b1);

    // Counter holds FFFF_FFFE in the cycle after the write's ack; 3 more idle cycles plus
    // 2-cycle latency puts the read ack 5 cycles later: FFFF_FFFE + 5 wraps to 3.
    access("cnt_wr", 1'b0, 32'h8000_0008, 1'b1, 32'hFFFF_FFFE, 32'h0, 2, 1'b1);
    repeat (3) tick;
    access("cnt_rd", 1'b0, 32'h8000_0008, 1'b0, 32'h0, 32'h0000_0003, 2, 1'b1);

    // Unmapped accesses.
    access("unm_rd", 1'b0, 32'h4000_0000, 1'b0, 32'h0, 32'h0, 2, 1'b1);
`ifdef WEAK_BUS_ERR_EN
    check("unm_err", {31'b0, last_err}, 32'd1);
    access("err_rd", 1'b0, 32'h8000_000C, 1'b0, 32'h0, 32'h4000_0001, 2, 1'b1);
    check("err_rd_noerr", {31'b0, last_err}, 32'd0);
    access("err_clr", 1'b0, 32'h8000_000C, 1'b1, 32'h1234_5678, 32'h0, 2, 1'b1);
    access("err_rd2", 1'b0, 32'h8000_000C, 1'b0, 32'h0, 32'h0, 2, 1'b1);
`else
    access("rsv_rd", 1'b0, 32'h8000_000C, 1'b0, 32'h0, 32'h0, 2, 1'b1);
`endif
    access("unm_wr", 1'b0, 32'h4000_0010, 1'b1, 32'h0BAD_F00D, 32'h0, 2, 1'b1);
    access("rd10b",  1'b0, 32'h10, 1'b0, 32'h0, 32'hDEAD_BEEF, 2, 1'b1);

    // Reset during WAIT of a store: no ack, no commit.
    access("pre20", 1'b0, 32'h20, 1'b1, 32'h1111_1111, 32'h0, 2, 1'b1);
    drive(1'b0, 1'b1, 32'h20, 1'b1, 32'h2222_2222);
    tick;
    check("rstw_wait_noack", {31'b0, bif1.bus_ack}, 32'd0);
    rst = 1'b1;
    tick;
    check("rstw_noack",  {31'b0, bif1.bus_ack}, 32'd0);
    check("rstw_txv",    {31'b0, tx_valid1}, 32'd0);
    rst = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    tick;
    check("rstw_idle",   {31'b0, bif1.bus_ack}, 32'd0);
    access("rd20a", 1'b0, 32'h20, 1'b0, 32'h0, 32'h1111_1111, 2, 1'b1);

    // Request withdrawn in WAIT: no ack, no write.
    drive(1'b0, 1'b1, 32'h20, 1'b1, 32'h3333_3333);
    tick;
    drive(1'b0, 1'b0, 32'h20, 1'b1, 32'h3333_3333);
    tick;
    check("drop_noack1", {31'b0, bif1.bus_ack}, 32'd0);
    tick;
    check("drop_noack2", {31'b0, bif1.bus_ack}, 32'd0);
    access("rd20b", 1'b0, 32'h20, 1'b0, 32'h0, 32'h1111_1111, 2, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
